instruction_fetch_unit: RTL

- Fetch stage directly upstream of the single-cycle processor core.
- Takes the core's program counter, issues one request at a time to the instruction memory over a valid/ready bus, and holds the returned word.
- Presents that word to the core's instruction input with a valid/ready handshake, which stalls the core during memory latency.
- Handles flushes on taken branches or jumps, misaligned PCs, bus errors and response timeouts.

---
 rtl/instruction_fetch_unit_pkg.sv | 23 ++
 rtl/instruction_fetch_unit_timeout.sv | 27 ++
 rtl/instruction_fetch_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the fetch stage.
// Fault causes are encoded here for the trap logic downstream.
package instruction_fetch_unit_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    VALID,
    DRAIN
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

  typedef enum logic [1:0] {
    FAULT_NONE,
    MISALIGNED,
    BUS_ERR,
    TIMEOUT
  } fault_cause_t;

endpackage

// File: rtl/instruction_fetch_unit_timeout.sv
// Response watchdog for the fetch stage.
// Counts up to TIMEOUT_CYCLES-1 and holds there until cleared.
module fetch_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] count;

  assign expired = (count == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: one outstanding request to instruction memory,
// the returned word is held for the core behind a valid/ready handshake.
module instruction_fetch_unit #(
  parameter int          ADDR_WIDTH     = 32,
  parameter logic [31:0] NOP_INSTR      = 32'h0000_0013,
  parameter int          TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  pc_valid,
  input  logic                  flush,
  output logic [31:0]           instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic                  fetch_fault,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_resp_valid,
  input  logic [31:0]           mem_resp_data,
  input  logic                  mem_resp_err
);

  import instruction_fetch_unit_pkg::*;

  fetch_state_t state;
  fetch_state_t state_next;
  logic         expired;
  logic         aligned;
  logic         done;

  assign aligned       = (pc[1:0] == 2'b00);
  assign done          = mem_resp_valid || expired;
  assign instr_valid   = (state == VALID);
  assign mem_req_valid = (state == REQ);

  fetch_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state == REQ),
    .enable ((state == WAIT) || (state == DRAIN)),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A flush racing an accepted request still owes us a response: drain it.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (pc_valid && !flush) begin
          state_next = aligned ? REQ : VALID;
        end
      end
      REQ: begin
        if (flush) begin
          state_next = mem_req_ready ? DRAIN : IDLE;
        end else if (mem_req_ready) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (flush) begin
          state_next = done ? IDLE : DRAIN;
        end else if (done) begin
          state_next = VALID;
        end
      end
      DRAIN: begin
        if (done) begin
          state_next = IDLE;
        end
      end
      VALID: begin
        if (flush || instr_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr        <= NOP_INSTR;
      instr_pc     <= '0;
      fetch_fault  <= 1'b0;
      mem_req_addr <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pc_valid && !flush) begin
            instr_pc <= pc;
            if (aligned) begin
              mem_req_addr <= {pc[ADDR_WIDTH-1:2], 2'b00};
            end else begin
              instr       <= NOP_INSTR;
              fetch_fault <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (!flush) begin
            if (mem_resp_valid) begin
              instr       <= mem_resp_data;
              fetch_fault <= mem_resp_err;
            end else if (expired) begin
              instr       <= NOP_INSTR;
              fetch_fault <= 1'b1;
            end
          end
        end
        VALID: begin
          if (flush || instr_ready) begin
            instr       <= NOP_INSTR;
            fetch_fault <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
